pkt_cksum_append: RTL

Stream stage that sits directly downstream of the skid buffer on the 8-bit valid/ready/last packet path. It forwards every payload byte unchanged and with zero latency. After each packet's last byte it inserts a one-byte two's-complement checksum trailer, so the 8-bit sum of all bytes of the emitted packet is 0x00. The trailer becomes the new `last` beat, and an optional length byte can follow it.

---
 rtl/pkt_cksum_append.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pkt_cksum_append.sv
// pkt_cksum_append
//   Byte-stream stage that forwards payload with zero latency and, after the
//   last payload byte, appends a two's-complement checksum trailer so that the
//   8-bit sum of every byte of the emitted packet is 0x00.
//
//   Build option: define PKT_CKSUM_LEN_TRAILER_EN to append a payload length
//   byte after the checksum. The checksum covers the payload only. The length
//   byte then carries s_last instead of the checksum byte.
//
// Ports
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   m_data/valid/last : upstream beat; m_ready is returned upstream
//   s_data/valid/last : downstream beat; s_ready comes from downstream
//   pkt_done          : one-cycle registered pulse after the final trailer beat
module pkt_cksum_append #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] m_data,
  input  logic              m_valid,
  input  logic              m_last,
  output logic              m_ready,
  output logic [DATA_W-1:0] s_data,
  output logic              s_valid,
  output logic              s_last,
  input  logic              s_ready,
  output logic              pkt_done
);

  typedef enum logic [1:0] {
    ST_PASS  = 2'd0,
`ifdef PKT_CKSUM_LEN_TRAILER_EN
    ST_CKSUM = 2'd1,
    ST_LEN   = 2'd2
`else
    ST_CKSUM = 2'd1
`endif
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] cksum;
`ifdef PKT_CKSUM_LEN_TRAILER_EN
  logic [DATA_W-1:0] len;
`endif

  assign cksum = ~acc + DATA_W'(1);

  // Trailer beats depend only on registered state, never on m_*, so the
  // trailer stays stable while downstream stalls.
  always_comb begin
    m_ready = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    if (!reset) begin
      case (state)
        ST_PASS: begin
          s_valid = m_valid;
          s_data  = m_data;
          m_ready = s_ready;
        end
        ST_CKSUM: begin
          s_valid = 1'b1;
          s_data  = cksum;
`ifdef PKT_CKSUM_LEN_TRAILER_EN
          s_last  = 1'b0;
`else
          s_last  = 1'b1;
`endif
        end
`ifdef PKT_CKSUM_LEN_TRAILER_EN
        ST_LEN: begin
          s_valid = 1'b1;
          s_data  = len;
          s_last  = 1'b1;
        end
`endif
        default: begin
          s_valid = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_PASS;
      acc      <= '0;
`ifdef PKT_CKSUM_LEN_TRAILER_EN
      len      <= '0;
`endif
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      case (state)
        ST_PASS: begin
          if (m_valid && s_ready) begin
            acc <= acc + m_data;
`ifdef PKT_CKSUM_LEN_TRAILER_EN
            len <= len + DATA_W'(1);
`endif
            if (m_last) state <= ST_CKSUM;
          end
        end
        ST_CKSUM: begin
          if (s_ready) begin
`ifdef PKT_CKSUM_LEN_TRAILER_EN
            state <= ST_LEN;
`else
            acc      <= '0;
            pkt_done <= 1'b1;
            state    <= ST_PASS;
`endif
          end
        end
`ifdef PKT_CKSUM_LEN_TRAILER_EN
        ST_LEN: begin
          if (s_ready) begin
            acc      <= '0;
            len      <= '0;
            pkt_done <= 1'b1;
            state    <= ST_PASS;
          end
        end
`endif
        default: state <= ST_PASS;
      endcase
    end
  end

endmodule
